resv_sched_pip0: RTL and testbench

Issue scheduler and occupancy controller for the 8-cell pip0 reservation station. Each cycle it:
- picks the oldest ready cell for execution pipe 0 or pipe 1;
- registers that cell's packet into the selected pipe's output stage;
- drives the station's shift and insert address buses so the array stays compacted toward cell 0.

It sits between the decoder (insert side), the reservation cell array and the two execution pipes.

---
 rtl/resv_sched_pip0_pkg.sv | 29 ++
 rtl/resv_sched_pip0_if.sv | 30 +++
 rtl/resv_oldest_pick.sv | 20 ++
 rtl/resv_sched_pip0.sv | 140 ++++++++++++++
 tb/tb_resv_sched_pip0.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/resv_sched_pip0_pkg.sv
// Shared sizes, field offsets and codes for the pip0 reservation station scheduler.
package resv_pkg;
  localparam int N_CELL  = 8;
  localparam int W_ident = 4;
  localparam int W_pkt   = 154;

  localparam logic [W_ident-1:0] unused_cd = {W_ident{1'b1}};
  localparam logic [W_ident-1:0] one_cd    = W_ident'(1);
  localparam logic [W_ident-1:0] full_cd   = W_ident'(N_CELL);

  // Packet field offsets, LSB first; pc_d ends at W_pkt.
  localparam int OFS_REQ   = 0;
  localparam int OFS_PIP   = 1;
  localparam int OFS_UOPS  = 2;
  localparam int OFS_RD_A  = 9;
  localparam int OFS_RS_V  = 14;
  localparam int OFS_RS_A  = 15;
  localparam int OFS_RS_D  = 20;
  localparam int OFS_RT_V  = 52;
  localparam int OFS_RT_A  = 53;
  localparam int OFS_RT_D  = 58;
  localparam int OFS_IMM_D = 90;
  localparam int OFS_PC_D  = 122;

  function automatic logic [W_ident-1:0] cell_code(input logic [N_CELL*W_ident-1:0] bus,
                                                   input int idx);
    return bus[idx*W_ident +: W_ident];
  endfunction
endpackage

// File: rtl/resv_sched_pip0_if.sv
// Station-side bundle: candidate codes, cell contents, decoder handshake and both pipe stages.
interface resv_sched_pip0_if;
  import resv_pkg::*;

  logic                      flush;
  logic [N_CELL*W_ident-1:0] cand0_bus;
  logic [N_CELL*W_ident-1:0] cand1_bus;
  logic [N_CELL*W_pkt-1:0]   cell_pkt;
  logic                      dec_valid;
  logic                      dec_ready;
  logic [W_ident-1:0]        addr_insert;
  logic [W_ident-1:0]        addr_shift;
  logic                      ex0_valid;
  logic                      ex1_valid;
  logic                      ex0_ready;
  logic                      ex1_ready;
  logic [W_pkt-1:0]          ex0_pkt;
  logic [W_pkt-1:0]          ex1_pkt;
  logic [W_ident-1:0]        count;

  modport master (
    output flush, cand0_bus, cand1_bus, cell_pkt, dec_valid, ex0_ready, ex1_ready,
    input  dec_ready, addr_insert, addr_shift, ex0_valid, ex1_valid, ex0_pkt, ex1_pkt, count
  );

  modport slave (
    input  flush, cand0_bus, cand1_bus, cell_pkt, dec_valid, ex0_ready, ex1_ready,
    output dec_ready, addr_insert, addr_shift, ex0_valid, ex1_valid, ex0_pkt, ex1_pkt, count
  );
endinterface

// File: rtl/resv_oldest_pick.sv
// Lowest-index priority encoder over the per-cell candidate codes (cell 0 = oldest).
module resv_oldest_pick
  import resv_pkg::*;
(
  input  logic [N_CELL*W_ident-1:0] cand_bus,
  output logic [W_ident-1:0]        idx,
  output logic                      found
);

  // Scan from oldest; the first non-unused code wins.
  always_comb begin
    idx   = unused_cd;
    found = 1'b0;
    for (int i = 0; i < N_CELL; i++) begin
      idx   = (!found && (cell_code(cand_bus, i) != unused_cd)) ? W_ident'(i) : idx;
      found = found | (cell_code(cand_bus, i) != unused_cd);
    end
  end

endmodule

// File: rtl/resv_sched_pip0.sv
// Issue scheduler and occupancy controller: oldest-ready issue to two pipes, compaction
// address generation and the count of occupied cells.
module resv_sched_pip0
  import resv_pkg::*;
(
  input  logic              clk,
  input  logic              clear_n,
  resv_sched_pip0_if.slave  bus
);

  logic [W_ident-1:0] count_r;
  logic               ex0_valid_r, ex1_valid_r;
  logic [W_pkt-1:0]   ex0_pkt_r, ex1_pkt_r;

  logic [W_ident-1:0] idx0_s, idx1_s, issue_idx_s;
  logic               found0_s, found1_s;
  logic               elig0_s, elig1_s, blocked_s;
  logic               issue_s, issue_p1_s;
  logic               dec_ready_s, insert_s;
  logic [W_ident-1:0] addr_insert_s, addr_shift_s;
  logic [W_pkt-1:0]   issue_pkt_s;

  resv_oldest_pick u_pick0 (.cand_bus(bus.cand0_bus), .idx(idx0_s), .found(found0_s));
  resv_oldest_pick u_pick1 (.cand_bus(bus.cand1_bus), .idx(idx1_s), .found(found1_s));

  // While in reset or flushing nothing may issue or insert.
  assign blocked_s   = bus.flush || !clear_n;
  assign elig0_s     = found0_s && (!ex0_valid_r || bus.ex0_ready);
  assign elig1_s     = found1_s && (!ex1_valid_r || bus.ex1_ready);
  assign dec_ready_s = !blocked_s && (count_r < full_cd);
  assign insert_s    = bus.dec_valid && dec_ready_s;

  // Single issue per cycle: the eligible pipe holding the older cell wins.
  always_comb begin
    issue_s     = 1'b0;
    issue_p1_s  = 1'b0;
    issue_idx_s = unused_cd;
    if (blocked_s) begin
      issue_s = 1'b0;
    end else if (elig0_s && elig1_s) begin
      issue_s     = 1'b1;
      issue_p1_s  = (idx1_s < idx0_s);
      issue_idx_s = issue_p1_s ? idx1_s : idx0_s;
    end else if (elig0_s) begin
      issue_s     = 1'b1;
      issue_idx_s = idx0_s;
    end else if (elig1_s) begin
      issue_s     = 1'b1;
      issue_p1_s  = 1'b1;
      issue_idx_s = idx1_s;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Mux the issuing cell's payload out of the flattened array.
  always_comb begin
    issue_pkt_s = '0;
    for (int i = 0; i < N_CELL; i++) begin
      issue_pkt_s = (issue_idx_s == W_ident'(i)) ? bus.cell_pkt[i*W_pkt +: W_pkt] : issue_pkt_s;
    end
  end

  // Compaction addresses; an issue below the tail pulls the insert slot down by one.
  always_comb begin
    addr_insert_s = unused_cd;
    addr_shift_s  = unused_cd;
    if (insert_s && issue_s) begin
      addr_insert_s = count_r - one_cd;
    end else if (insert_s) begin
      addr_insert_s = count_r;
    end else begin
      addr_insert_s = unused_cd;
    end
    if (issue_s) begin
      addr_shift_s = issue_idx_s;
    end else begin
      addr_shift_s = unused_cd;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count_r <= '0;
    end else if (bus.flush) begin
      count_r <= '0;
    end else if (issue_s && !insert_s) begin
      count_r <= count_r - one_cd;
    end else if (insert_s && !issue_s) begin
      count_r <= count_r + one_cd;
    end else begin
      count_r <= count_r;
    end
  end

  // Pipe 0 output stage.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ex0_valid_r <= 1'b0;
      ex0_pkt_r   <= '0;
    end else if (bus.flush) begin
      ex0_valid_r <= 1'b0;
    end else if (issue_s && !issue_p1_s) begin
      ex0_valid_r <= 1'b1;
      ex0_pkt_r   <= issue_pkt_s;
    end else if (bus.ex0_ready) begin
      ex0_valid_r <= 1'b0;
    end else begin
      ex0_valid_r <= ex0_valid_r;
    end
  end

  // Pipe 1 output stage.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ex1_valid_r <= 1'b0;
      ex1_pkt_r   <= '0;
    end else if (bus.flush) begin
      ex1_valid_r <= 1'b0;
    end else if (issue_s && issue_p1_s) begin
      ex1_valid_r <= 1'b1;
      ex1_pkt_r   <= issue_pkt_s;
    end else if (bus.ex1_ready) begin
      ex1_valid_r <= 1'b0;
    end else begin
      ex1_valid_r <= ex1_valid_r;
    end
  end

  assign bus.dec_ready   = dec_ready_s;
  assign bus.addr_insert = addr_insert_s;
  assign bus.addr_shift  = addr_shift_s;
  assign bus.count       = count_r;
  assign bus.ex0_valid   = ex0_valid_r;
  assign bus.ex1_valid   = ex1_valid_r;
  assign bus.ex0_pkt     = ex0_pkt_r;
  assign bus.ex1_pkt     = ex1_pkt_r;

endmodule

// File: tb/tb_resv_sched_pip0.sv
// Bench for resv_sched_pip0: the bench owns the cell array as a queue and predicts issue,
// compaction addresses and pipe stages from the age/readiness rules.
module tb_resv_sched_pip0;
  import resv_pkg::*;

  typedef struct {
    logic [W_pkt-1:0] pkt;
    bit               pip;
    bit               rdy;
  } cell_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;

  resv_sched_pip0_if bus_if ();
  resv_sched_pip0 dut (.clk(clk), .clear_n(clear_n), .bus(bus_if));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  cell_t            q[$];
  bit               m_v0, m_v1;
  logic [W_pkt-1:0] m_p0, m_p1;
  bit               rnd_mode = 1'b0;
  int               ins_pip = -1;
  int               ins_rdy = 0;

  bit               c_dv, c_r0, c_r1, c_fl;
  bit               e_issue, e_ins, e_dready;
  int               e_k;
  logic [W_ident-1:0] e_shift, e_insert;

  function automatic logic [W_pkt-1:0] rand_pkt();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W_pkt-1:0];
  endfunction

  // Present the modelled array and inputs, then predict this cycle's combinational outputs.
  task automatic drive(input bit dv, input bit r0, input bit r1, input bit fl);
    c_dv = dv; c_r0 = r0; c_r1 = r1; c_fl = fl;
    bus_if.dec_valid = dv;
    bus_if.ex0_ready = r0;
    bus_if.ex1_ready = r1;
    bus_if.flush     = fl;
    for (int i = 0; i < N_CELL; i++) begin
      if (i < q.size()) begin
        bus_if.cand0_bus[i*W_ident +: W_ident] = (q[i].rdy && !q[i].pip) ? W_ident'(i) : unused_cd;
        bus_if.cand1_bus[i*W_ident +: W_ident] = (q[i].rdy &&  q[i].pip) ? W_ident'(i) : unused_cd;
        bus_if.cell_pkt[i*W_pkt +: W_pkt] = q[i].pkt;
      end else begin
        bus_if.cand0_bus[i*W_ident +: W_ident] = unused_cd;
        bus_if.cand1_bus[i*W_ident +: W_ident] = unused_cd;
        bus_if.cell_pkt[i*W_pkt +: W_pkt] = '0;
      end
    end
    #1;
    e_dready = !fl && (q.size() < N_CELL);
    e_ins    = dv && e_dready;
    e_k      = -1;
    if (!fl) begin
      for (int i = 0; i < q.size(); i++) begin
        if (e_k < 0 && q[i].rdy && (q[i].pip ? (!m_v1 || r1) : (!m_v0 || r0))) e_k = i;
      end
    end
    e_issue  = (e_k >= 0);
    e_shift  = e_issue ? W_ident'(e_k) : unused_cd;
    e_insert = e_ins ? W_ident'(q.size() - (e_issue ? 1 : 0)) : unused_cd;
  endtask

  // Apply the cycle's effect to the model, then move to the next falling edge.
  task automatic advance();
    cell_t c;
    if (c_fl) begin
      q.delete();
      m_v0 = 1'b0;
      m_v1 = 1'b0;
    end else begin
      if (e_issue && !q[e_k].pip) begin m_v0 = 1'b1; m_p0 = q[e_k].pkt; end
      else m_v0 = m_v0 && !c_r0;
      if (e_issue && q[e_k].pip) begin m_v1 = 1'b1; m_p1 = q[e_k].pkt; end
      else m_v1 = m_v1 && !c_r1;
      if (e_issue) q.delete(e_k);
      if (e_ins) begin
        c.pkt = rand_pkt();
        c.pip = (ins_pip < 0) ? 1'($urandom_range(0, 1)) : 1'(ins_pip);
        c.rdy = (ins_rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(ins_rdy);
        q.push_back(c);
      end
      if (rnd_mode) begin
        foreach (q[i]) q[i].rdy = q[i].rdy | ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_v0 = 1'b0; m_v1 = 1'b0; m_p0 = '0; m_p1 = '0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus_if.count); end
    n_cmp++; if (bus_if.ex0_valid !== 1'b0 || bus_if.ex1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b%b want 00", bus_if.ex0_valid, bus_if.ex1_valid); end
    n_cmp++; if (bus_if.ex0_pkt !== '0 || bus_if.ex1_pkt !== '0) begin n_bad++; $display("FAIL reset_pkt: got %0h/%0h want 0", bus_if.ex0_pkt, bus_if.ex1_pkt); end
    n_cmp++; if (bus_if.dec_ready !== 1'b1) begin n_bad++; $display("FAIL reset_dec_ready: got %b want 1", bus_if.dec_ready); end
    n_cmp++; if (bus_if.addr_insert !== unused_cd || bus_if.addr_shift !== unused_cd) begin n_bad++; $display("FAIL reset_addr: got %0h/%0h want f/f", bus_if.addr_insert, bus_if.addr_shift); end
    advance();
  endtask

  task automatic test_insert();
    logic [W_ident-1:0] want;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      want = W_ident'(i);
      n_cmp++; if (bus_if.addr_insert !== want) begin n_bad++; $display("FAIL insert_addr: got %0d want %0d", bus_if.addr_insert, want); end
      n_cmp++; if (bus_if.addr_shift !== unused_cd) begin n_bad++; $display("FAIL insert_shift: got %0h want f", bus_if.addr_shift); end
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.count !== 4'd3) begin n_bad++; $display("FAIL insert_count: got %0d want 3", bus_if.count); end
    advance();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d want 8", bus_if.count); end
    n_cmp++; if (bus_if.dec_ready !== 1'b0) begin n_bad++; $display("FAIL full_dec_ready: got %b want 0", bus_if.dec_ready); end
    n_cmp++; if (bus_if.addr_insert !== unused_cd) begin n_bad++; $display("FAIL full_insert: got %0h want f", bus_if.addr_insert); end
    advance();
  endtask

  task automatic test_oldest_first();
    logic [W_pkt-1:0] saved;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus_if.dec_ready !== 1'b0 || bus_if.addr_insert !== unused_cd) begin n_bad++; $display("FAIL flush_block: got rdy=%b ins=%0h want 0/f", bus_if.dec_ready, bus_if.addr_insert); end
    advance();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    q[2].pip = 1'b1; q[2].rdy = 1'b1;
    q[5].pip = 1'b0; q[5].rdy = 1'b1;
    saved = q[2].pkt;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus_if.addr_shift !== 4'd2) begin n_bad++; $display("FAIL oldest_shift: got %0h want 2", bus_if.addr_shift); end
    advance();
    q[4].rdy = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.ex1_valid !== 1'b1 || bus_if.ex1_pkt !== saved) begin n_bad++; $display("FAIL oldest_pkt: got v=%b %0h want 1 %0h", bus_if.ex1_valid, bus_if.ex1_pkt, saved); end
    n_cmp++; if (bus_if.count !== 4'd5 || bus_if.ex0_valid !== 1'b0) begin n_bad++; $display("FAIL oldest_count: got %0d v0=%b want 5 0", bus_if.count, bus_if.ex0_valid); end
    advance();
  endtask

  task automatic test_insert_issue();
    q[1].pip = 1'b0; q[1].rdy = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus_if.addr_insert !== 4'd4) begin n_bad++; $display("FAIL both_insert: got %0h want 4", bus_if.addr_insert); end
    n_cmp++; if (bus_if.addr_shift !== 4'd1) begin n_bad++; $display("FAIL both_shift: got %0h want 1", bus_if.addr_shift); end
    advance();
  endtask

  task automatic test_backpressure();
    logic [W_pkt-1:0] held, c0;
    held = m_p0;
    q[0].pip = 1'b0; q[0].rdy = 1'b1;
    c0 = q[0].pkt;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.count !== 4'd5) begin n_bad++; $display("FAIL both_count: got %0d want 5", bus_if.count); end
    n_cmp++; if (bus_if.addr_shift !== unused_cd) begin n_bad++; $display("FAIL bp_shift: got %0h want f", bus_if.addr_shift); end
    n_cmp++; if (bus_if.ex0_valid !== 1'b1 || bus_if.ex0_pkt !== held) begin n_bad++; $display("FAIL bp_hold: got v=%b %0h want 1 %0h", bus_if.ex0_valid, bus_if.ex0_pkt, held); end
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus_if.addr_shift !== 4'd0) begin n_bad++; $display("FAIL bp_release: got %0h want 0", bus_if.addr_shift); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.ex0_pkt !== c0 || bus_if.count !== 4'd4) begin n_bad++; $display("FAIL bp_issue: got %0h cnt=%0d want %0h 4", bus_if.ex0_pkt, bus_if.count, c0); end
    advance();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus_if.count !== 4'd6 || bus_if.ex1_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre: got cnt=%0d v1=%b want 6 1", bus_if.count, bus_if.ex1_valid); end
    n_cmp++; if (bus_if.addr_shift !== unused_cd || bus_if.addr_insert !== unused_cd || bus_if.dec_ready !== 1'b0) begin n_bad++; $display("FAIL flush_comb: got %0h/%0h rdy=%b want f/f 0", bus_if.addr_shift, bus_if.addr_insert, bus_if.dec_ready); end
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.count !== 4'd0 || bus_if.ex1_valid !== 1'b0 || bus_if.ex0_valid !== 1'b0) begin n_bad++; $display("FAIL flush_post: got cnt=%0d v=%b%b want 0 00", bus_if.count, bus_if.ex0_valid, bus_if.ex1_valid); end
    advance();
  endtask

  task automatic test_random();
    rnd_mode = 1'b1; ins_pip = -1; ins_rdy = -1;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0);
      n_cmp++; if (bus_if.addr_shift !== e_shift) begin n_bad++; $display("FAIL rnd_shift@%0d: got %0h want %0h", n, bus_if.addr_shift, e_shift); end
      n_cmp++; if (bus_if.addr_insert !== e_insert) begin n_bad++; $display("FAIL rnd_insert@%0d: got %0h want %0h", n, bus_if.addr_insert, e_insert); end
      n_cmp++; if (bus_if.dec_ready !== e_dready) begin n_bad++; $display("FAIL rnd_dec_ready@%0d: got %b want %b", n, bus_if.dec_ready, e_dready); end
      n_cmp++; if (bus_if.count !== W_ident'(q.size())) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, bus_if.count, q.size()); end
      n_cmp++; if (bus_if.ex0_valid !== m_v0 || (m_v0 && bus_if.ex0_pkt !== m_p0)) begin n_bad++; $display("FAIL rnd_ex0@%0d: got v=%b %0h want v=%b %0h", n, bus_if.ex0_valid, bus_if.ex0_pkt, m_v0, m_p0); end
      n_cmp++; if (bus_if.ex1_valid !== m_v1 || (m_v1 && bus_if.ex1_pkt !== m_p1)) begin n_bad++; $display("FAIL rnd_ex1@%0d: got v=%b %0h want v=%b %0h", n, bus_if.ex1_valid, bus_if.ex1_pkt, m_v1, m_p1); end
      advance();
    end
    rnd_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    ins_rdy = 1;
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); advance(); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    #2 clear_n = 1'b0;
    #1;
    n_cmp++; if (bus_if.count !== 4'd0 || bus_if.ex0_valid !== 1'b0 || bus_if.ex1_valid !== 1'b0) begin n_bad++; $display("FAIL arst_state: got cnt=%0d v=%b%b want 0 00", bus_if.count, bus_if.ex0_valid, bus_if.ex1_valid); end
    n_cmp++; if (bus_if.ex0_pkt !== '0 || bus_if.ex1_pkt !== '0) begin n_bad++; $display("FAIL arst_pkt: got %0h/%0h want 0", bus_if.ex0_pkt, bus_if.ex1_pkt); end
    n_cmp++; if (bus_if.addr_insert !== unused_cd || bus_if.addr_shift !== unused_cd) begin n_bad++; $display("FAIL arst_addr: got %0h/%0h want f/f", bus_if.addr_insert, bus_if.addr_shift); end
    model_reset();
    @(negedge clk);
    clear_n = 1'b1;
    ins_rdy = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus_if.dec_ready !== 1'b1 || bus_if.count !== 4'd0) begin n_bad++; $display("FAIL arst_release: got rdy=%b cnt=%0d want 1 0", bus_if.dec_ready, bus_if.count); end
    advance();
  endtask

  initial begin
    model_reset();
    bus_if.flush = 1'b0; bus_if.dec_valid = 1'b0;
    bus_if.ex0_ready = 1'b0; bus_if.ex1_ready = 1'b0;
    bus_if.cand0_bus = {(N_CELL*W_ident){1'b1}};
    bus_if.cand1_bus = {(N_CELL*W_ident){1'b1}};
    bus_if.cell_pkt  = '0;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    test_reset();
    test_insert();
    test_fill();
    test_oldest_first();
    test_insert_issue();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
